// File: rtl/alu_sched_pkg.sv
`default_nettype none
//==========================================================================
// Package  : alu_sched_pkg
// Brief    : Shared opcodes, FSM state type and command record for the
//            ALU command scheduler.
// Revision : 1.0 - initial release
//==========================================================================
package alu_sched_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;

    // Width of the tag slot inside a queued command; the scheduler's TAG_W
    // is expected to match it.
    localparam int CMD_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [7:0]           a;
        logic [7:0]           b;
        logic [3:0]           sel;
        logic [CMD_TAG_W-1:0] tag;
    } alu_cmd_t;

    // Opcodes the ALU cannot execute meaningfully: unknown selects and x/0.
    function automatic logic cmd_is_illegal(input logic [7:0] b, input logic [3:0] sel);
        return (sel > ALU_DIV) || ((sel == ALU_DIV) && (b == 8'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
//==========================================================================
// Module   : alu_cmd_fifo
// Brief    : DEPTH-entry show-ahead synchronous FIFO of alu_cmd_t with
//            asynchronous reset and full/empty/occupancy outputs.
// Revision : 1.0 - initial release
//==========================================================================
module alu_cmd_fifo
    import alu_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  alu_cmd_t                 wdata,
    input  logic                     pop,
    output alu_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic              do_push;
    logic              do_pop;

    assign full    = (occ == (AW+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = occ;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_scheduler.sv
`default_nettype none
//==========================================================================
// Module   : alu_cmd_scheduler
// Brief    : Buffers tagged ALU commands, issues them one at a time to the
//            registered ALU and returns tagged results over valid/ready.
//            Option ALU_SCHED_ERR_CHECK_EN: reject illegal ops / x/0 at pop.
// Revision : 1.0 - initial release
//==========================================================================
module alu_cmd_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = CMD_TAG_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [3:0]               cmd_sel,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [3:0]               alu_sel,
    input  logic [7:0]               alu_out,
    input  logic                     alu_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic                     rsp_carry,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   count
);

    sched_state_t        state;
    alu_cmd_t            push_cmd;
    alu_cmd_t            head;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                issue_err;
    logic [3:0]          sel_q;
    logic [TAG_W-1:0]    tag_q;
    logic                err_q;

    assign push_cmd = '{a: cmd_a, b: cmd_b, sel: cmd_sel, tag: CMD_TAG_W'(cmd_tag)};

    // Ready only reflects occupancy, so a full FIFO refuses even on a pop cycle.
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    // A new command leaves the FIFO from IDLE, or straight out of RESP on the
    // response handshake so back-to-back commands see no idle bubble.
    assign pop = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));

`ifdef ALU_SCHED_ERR_CHECK_EN
    assign issue_err = cmd_is_illegal(head.b, head.sel);
`else
    assign issue_err = 1'b0;
`endif

    assign rsp_err = err_q;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            sel_q     <= '0;
            tag_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_tag   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                EXEC: begin
                    state <= CAPT;
                end
                CAPT: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_out;
                    rsp_carry <= (sel_q == ALU_ADD) && alu_carry;
                    rsp_tag   <= tag_q;
                    err_q     <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        err_q     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Issue overrides the per-state defaults above.
            if (pop) begin
                if (issue_err) begin
                    rsp_valid <= 1'b1;
                    err_q     <= 1'b1;
                    rsp_data  <= '0;
                    rsp_carry <= 1'b0;
                    rsp_tag   <= TAG_W'(head.tag);
                    state     <= RESP;
                end else begin
                    alu_a     <= head.a;
                    alu_b     <= head.b;
                    alu_sel   <= head.sel;
                    sel_q     <= head.sel;
                    tag_q     <= TAG_W'(head.tag);
                    state     <= EXEC;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_scheduler.sv
`default_nettype none
// Testbench for alu_cmd_scheduler with a behavioural registered ALU and a
// queue-based response model.
module tb_alu_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [7:0]             cmd_a;
    logic [7:0]             cmd_b;
    logic [3:0]             cmd_sel;
    logic [TAG_W-1:0]       cmd_tag;
    logic [7:0]             alu_a;
    logic [7:0]             alu_b;
    logic [3:0]             alu_sel;
    logic [7:0]             alu_out = 8'd0;
    logic                   alu_carry = 1'b0;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [7:0]             rsp_data;
    logic                   rsp_carry;
    logic [TAG_W-1:0]       rsp_tag;
    logic                   rsp_err;
    logic [$clog2(DEPTH):0] count;

    always #5 clock = ~clock;

    alu_cmd_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .cmd_tag   (cmd_tag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .count     (count)
    );

    // Registered 8-bit ALU
    always @(posedge clock) begin
        case (alu_sel)
            4'd0:    alu_out <= alu_a + alu_b;
            4'd1:    alu_out <= alu_a - alu_b;
            4'd2:    alu_out <= 8'(16'(alu_a) * 16'(alu_b));
            4'd3:    alu_out <= (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b;
            default: alu_out <= 8'hAC;
        endcase
        alu_carry <= (9'(alu_a) + 9'(alu_b)) > 9'd255;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response {err, carry, data} from the arithmetic rules
    function automatic logic [9:0] ref_rsp(input int a, input int b, input int sel);
        int   r;
        logic c;
        c = 1'b0;
`ifdef ALU_SCHED_ERR_CHECK_EN
        if (sel >= 4 || (sel == 3 && b == 0)) return 10'b10_0000_0000;
`endif
        case (sel)
            0:       begin r = a + b; c = (r > 255); end
            1:       r = a - b + 256;
            2:       r = a * b;
            3:       r = (b == 0) ? 0 : a / b;
            default: r = 172;
        endcase
        return {1'b0, c, 8'(r % 256)};
    endfunction

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [9:0]       rsp;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_mon;
    logic        stall_prev = 1'b0;
    logic [63:0] snap = '0;

    // Scoreboard: handshakes seen here complete at the following rising edge.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("rsp_hold", 64'({rsp_valid, rsp_err, rsp_carry, rsp_tag, rsp_data, alu_a, alu_b, alu_sel}), snap);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    chk("rsp_order", 64'({rsp_tag, rsp_err, rsp_carry, rsp_data}), 64'({e_mon.tag, e_mon.rsp}));
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{cmd_tag, ref_rsp(int'(cmd_a), int'(cmd_b), int'(cmd_sel))});
            end
            stall_prev = rsp_valid && !rsp_ready;
            snap = 64'({rsp_valid, rsp_err, rsp_carry, rsp_tag, rsp_data, alu_a, alu_b, alu_sel});
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, input logic [3:0] tag);
        logic ok;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("push_accept", 64'(ok), 64'(1));
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            @(posedge clock);
            #1;
            edges++;
        end while (!rsp_valid && edges < 30);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [3:0] tag;
        logic [7:0] d;
        logic       c;
        logic       e;
    } vec_t;

    vec_t vt[8];
    bit   done_rand = 1'b0;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int         lat;
        int         seen;
        logic [3:0] sel_before;
        reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
        rsp_ready = 1'b0;

        vt[0] = '{8'd200, 8'd100, 4'd0, 4'd3,  8'd44,  1'b1, 1'b0};
        vt[1] = '{8'd5,   8'd7,   4'd1, 4'd5,  8'hFE,  1'b0, 1'b0};
        vt[2] = '{8'd16,  8'd17,  4'd2, 4'd6,  8'h10,  1'b0, 1'b0};
        vt[3] = '{8'd9,   8'd2,   4'd3, 4'd7,  8'd4,   1'b0, 1'b0};
        vt[4] = '{8'd255, 8'd1,   4'd0, 4'd8,  8'd0,   1'b1, 1'b0};
        vt[5] = '{8'd0,   8'd1,   4'd1, 4'd9,  8'hFF,  1'b0, 1'b0};
`ifdef ALU_SCHED_ERR_CHECK_EN
        vt[6] = '{8'd1,   8'd2,   4'hF, 4'd10, 8'h00,  1'b0, 1'b1};
        vt[7] = '{8'd7,   8'd0,   4'd3, 4'd11, 8'h00,  1'b0, 1'b1};
`else
        vt[6] = '{8'd1,   8'd2,   4'hF, 4'd10, 8'hAC,  1'b0, 1'b0};
        vt[7] = '{8'd100, 8'd3,   4'd3, 4'd11, 8'd33,  1'b0, 1'b0};
`endif

        repeat (2) @(posedge clock);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reset_count",     64'(count),     64'(0));
        chk("reset_alu",       64'({alu_a, alu_b, alu_sel}), 64'(0));
        chk("reset_rsp",       64'({rsp_data, rsp_carry, rsp_tag, rsp_err}), 64'(0));
        reset = 1'b0;

        // Isolated commands: latency and result fields
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel_before = alu_sel;
            push(vt[i].a, vt[i].b, vt[i].sel, vt[i].tag);
            wait_valid(lat);
            chk("vec_latency", 64'(lat), vt[i].e ? 64'(1) : 64'(3));
            chk("vec_data",    64'(rsp_data),  64'(vt[i].d));
            chk("vec_carry",   64'(rsp_carry), 64'(vt[i].c));
            chk("vec_err",     64'(rsp_err),   64'(vt[i].e));
            chk("vec_tag",     64'(rsp_tag),   64'(vt[i].tag));
            if (vt[i].e) chk("err_no_issue", 64'(alu_sel), 64'(sel_before));
            repeat (2) @(posedge clock);
            #1;
        end

        // Fill while stalled, hold 10 cycles, then drain back-to-back
        rsp_ready = 1'b0;
        push(8'd200, 8'd100, 4'd0, 4'd1);
        wait_valid(lat);
        push(8'd5, 8'd7, 4'd1, 4'd2);
        push(8'd16, 8'd17, 4'd2, 4'd3);
        push(8'd9, 8'd2, 4'd3, 4'd4);
        push(8'd50, 8'd60, 4'd0, 4'd5);
        chk("full_ready", 64'(cmd_ready), 64'(0));
        chk("full_count", 64'(count), 64'(4));
        fork
            push(8'd3, 8'd4, 4'd2, 4'd6);
        join_none
        repeat (10) @(posedge clock);
        #1;
        chk("hold_data",    64'(rsp_data), 64'(44));
        chk("hold_alu_sel", 64'(alu_sel),  64'(0));
        chk("hold_count",   64'(count),    64'(4));
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(lat);
            chk("b2b_gap", 64'(lat), 64'(3));
        end
        wait fork;
        repeat (3) @(posedge clock);
        #1;

        // Push and pop on the same edge at count 2
        rsp_ready = 1'b0;
        push(8'd10, 8'd20, 4'd0, 4'd7);
        wait_valid(lat);
        push(8'd30, 8'd3, 4'd1, 4'd8);
        push(8'd40, 8'd2, 4'd2, 4'd9);
        chk("pp_count_before", 64'(count), 64'(2));
        cmd_a = 8'd77; cmd_b = 8'd7; cmd_sel = 4'd3; cmd_tag = 4'd10;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("pp_count_after", 64'(count), 64'(2));
        rsp_ready = 1'b1;
        repeat (15) @(posedge clock);
        #1;
        chk("pp_drain_queue", 64'(exp_q.size()), 64'(0));
        chk("pp_drain_count", 64'(count), 64'(0));

        // Reset while a command executes with two still queued
        rsp_ready = 1'b0;
        push(8'd1, 8'd1, 4'd0, 4'd1);
        wait_valid(lat);
        push(8'd2, 8'd2, 4'd1, 4'd2);
        push(8'd3, 8'd3, 4'd2, 4'd3);
        push(8'd4, 8'd4, 4'd0, 4'd4);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        chk("pre_reset_count", 64'(count), 64'(2));
        reset = 1'b1;
        #1;
        chk("mid_reset_alu",   64'({alu_a, alu_b, alu_sel}), 64'(0));
        chk("mid_reset_rsp",   64'({rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err}), 64'(0));
        chk("mid_reset_count", 64'(count), 64'(0));
        chk("mid_reset_ready", 64'(cmd_ready), 64'(1));
        @(posedge clock);
        #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (rsp_valid) seen = 1;
        end
        chk("no_rsp_after_reset", 64'(seen), 64'(0));

        // Randomized traffic with random backpressure
        fork
            begin
                logic [7:0] ra;
                logic [7:0] rb;
                logic [3:0] rs;
                int         r;
                for (int i = 0; i < 150; i++) begin
                    ra = 8'($urandom);
                    rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                    r  = int'($urandom_range(0, 9));
                    rs = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
`ifndef ALU_SCHED_ERR_CHECK_EN
                    if (rs == 4'd3 && rb == 8'd0) rb = 8'd1;
`endif
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                    push(ra, rb, rs, 4'($urandom));
                end
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge clock);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        chk("random_drain", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
